// File: rtl/exec_pkg.sv
// Shared definitions for the execution-unit wrappers: widths, logic-op
// encodings and the payload layouts carried through the issue pipeline.
package exec_pkg;

    localparam int W_OPR = 32;
    localparam int W_REG = 5;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_NOT = 2'b10;
    localparam logic [1:0] LOGIC_XOR = 2'b11;

    // Issue stage contents: everything the logic unit needs plus the tag
    // that travels on to writeback.
    typedef struct packed {
        logic [W_OPR-1:0] opr0;
        logic [W_OPR-1:0] opr1;
        logic [1:0]       select;
        logic [W_REG-1:0] dst;
    } issue_payload_t;

    // Result stage contents presented to writeback.
    typedef struct packed {
        logic [W_OPR-1:0] result;
        logic [W_REG-1:0] dst;
    } result_payload_t;

endpackage

// File: rtl/exec_pipe_stage.sv
// Single valid/ready register slice with synchronous flush. Accepts a new
// word whenever it is empty or its current word leaves in the same cycle,
// so a chain of these runs at full throughput.
module exec_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         down_valid_o,
    input  logic         down_ready_i,
    output logic [W-1:0] down_data_o
);

    logic take;
    logic valid_q;
    logic [W-1:0] data_q;

    assign up_ready_o   = !valid_q || down_ready_i;
    assign take         = up_valid_i && up_ready_o;
    assign down_valid_o = valid_q;
    assign down_data_o  = data_q;

    // Occupancy: flush empties the slice, otherwise fill on take and empty when the word leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q <= 1'b1;
        end else if (down_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload loads only on an accepted word, and a flush blocks even that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (take && !flush_i) begin
            data_q <= up_data_i;
        end
    end

endmodule

// File: rtl/exec_logic_issue.sv
// Issue and result-collection wrapper around the combinational logic unit.
// Stage A registers the decoded op and drives the unit; stage B captures the
// unit's result for writeback. Both stages are exec_pipe_stage slices.
module exec_logic_issue
    import exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [W_OPR-1:0] in_opr0_i,
    input  logic [W_OPR-1:0] in_opr1_i,
    input  logic [W_REG-1:0] in_dst_i,
    output logic [W_OPR-1:0] opr0_o,
    output logic [W_OPR-1:0] opr1_o,
    output logic [1:0]       select_o,
    input  logic [W_OPR-1:0] result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OPR-1:0] out_result_o,
    output logic [W_REG-1:0] out_dst_o
);

    issue_payload_t  a_in;
    issue_payload_t  a_q;
    result_payload_t b_in;
    result_payload_t b_q;
    logic            a_valid;
    logic            b_ready;

    // The op code goes to the unit untouched; opr1 is carried even for NOT.
    assign a_in.opr0   = in_opr0_i;
    assign a_in.opr1   = in_opr1_i;
    assign a_in.select = in_op_i;
    assign a_in.dst    = in_dst_i;

    assign b_in.result = result_i;
    assign b_in.dst    = a_q.dst;

    exec_pipe_stage #(
        .W($bits(issue_payload_t))
    ) u_stage_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .up_valid_i   (in_valid_i),
        .up_ready_o   (in_ready_o),
        .up_data_i    (a_in),
        .down_valid_o (a_valid),
        .down_ready_i (b_ready),
        .down_data_o  (a_q)
    );

    exec_pipe_stage #(
        .W($bits(result_payload_t))
    ) u_stage_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .up_valid_i   (a_valid),
        .up_ready_o   (b_ready),
        .up_data_i    (b_in),
        .down_valid_o (out_valid_o),
        .down_ready_i (out_ready_i),
        .down_data_o  (b_q)
    );

    assign opr0_o       = a_q.opr0;
    assign opr1_o       = a_q.opr1;
    assign select_o     = a_q.select;
    assign out_result_o = b_q.result;
    assign out_dst_o    = b_q.dst;

endmodule

// File: doc/exec_logic_issue.md
# exec_logic_issue

Issue and result-collection wrapper for the logic execution unit. It accepts decoded logic operations from the dispatch stage over a valid/ready handshake. It drives the operand and select inputs of the combinational logic unit from a registered stage, and captures the unit's result into an output register. That register feeds writeback over a second valid/ready handshake. Two-stage pipeline with full-throughput backpressure and a synchronous flush.

## Interface
- W_OPR, 32, operand/result width (shared params)
- W_REG, 5, destination register index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous pipeline flush (branch mispredict/exception)
- in_valid_i  in  1  dispatch offers an operation
- in_ready_o  out  1  block accepts the operation this cycle
- in_op_i  in  2  logic op: 00 AND, 01 OR, 10 NOT, 11 XOR
- in_opr0_i  in  W_OPR  operand 0
- in_opr1_i  in  W_OPR  operand 1 (ignored for NOT)
- in_dst_i  in  W_REG  destination register
- opr0_o  out  W_OPR  to logic unit operand 0 (registered)
- opr1_o  out  W_OPR  to logic unit operand 1 (registered)
- select_o  out  2  to logic unit select (registered, same encoding as in_op_i)
- result_i  in  W_OPR  from logic unit, combinational function of the three outputs above
- out_valid_o  out  1  result available for writeback
- out_ready_i  in  1  writeback consumes result
- out_result_o  out  W_OPR  registered result
- out_dst_o  out  W_REG  registered destination

## Operation
- Stage A holds a_valid, opr0, opr1, select, dst; its outputs drive the logic unit directly.
- Stage B holds b_valid, result, dst; these drive the out_* ports.
- Advance rules:
  - b_take = a_valid & (!b_valid | out_ready_i)
  - a_take = in_valid_i & in_ready_o
  - in_ready_o = !a_valid | b_take
- On b_take, B loads result_i and A.dst. On a_take, A loads the in_* fields.
- A becomes valid on a_take. It becomes invalid on b_take without a_take.
- B becomes valid on b_take. It becomes invalid when out_ready_i fires without b_take.
- Payload registers in A and B load only on their take; otherwise they hold. Outputs never change while a valid is waiting on ready.
- in_op_i is passed through unmodified. NOT result = ~opr0. opr1 is still registered for NOT but has no effect on the result.
- flush_i: at the next edge, a_valid and b_valid go to 0 and the in_ready_o handshake of that cycle is discarded. Payload registers keep their values. flush_i has priority over every take.
- Reset (rst_n low, asynchronous): a_valid=0, b_valid=0, opr0_o=opr1_o=0, select_o=00, out_result_o=0, out_dst_o=0. Consequently in_ready_o=1 and out_valid_o=0. Release is synchronous to clk.

## Timing
- Latency: an op accepted at edge t drives the logic unit after t and appears on out_valid_o after edge t+1. Two edges from acceptance to result.
- Throughput: one op per cycle while out_ready_i stays high.
- in_ready_o depends combinationally on a_valid, b_valid and out_ready_i. It must not depend on in_valid_i.
- Backpressure: with out_ready_i low, B holds, then A holds, then in_ready_o drops. Two ops are buffered at most.
- Simultaneous B drain and refill from A, plus A refill from input in the same cycle, is legal and loses nothing.
- Reset asserted mid-operation discards all in-flight ops immediately, without waiting for an edge.

## Structure
- Shared package (exec_pkg) holds:
  - W_OPR and W_REG
  - logic-op constants LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_NOT=2'b10, LOGIC_XOR=2'b11
- One sub-module, exec_pipe_stage, is natural: a parameterised valid/ready register slice with flush. Instantiate it twice, for A (payload opr0/opr1/select/dst) and B (payload result/dst).
- The logic unit is instantiated by the parent, not inside this block.

## Test plan
- Reset, then single AND: in 0x00FF_F0F0 & 0x0F0F_FFFF, dst 3. Require select_o=00 one cycle after accept, then out_valid_o=1, out_result_o=0x000F_F0F0, out_dst_o=3 the following cycle.
- Back-to-back stream: OR, XOR, NOT with out_ready_i=1. Require one result per cycle in order and in_ready_o constantly 1. NOT of 0x0000_FFFF must give 0xFFFF_0000 regardless of opr1.
- Backpressure: hold out_ready_i=0 while offering 3 ops. Require exactly 2 accepted, in_ready_o=0 on the third, and out_* stable. Raising out_ready_i drains the buffered ops in order.
- Flush: two ops in flight, pulse flush_i for one cycle with in_valid_i=1. Require out_valid_o=0 next cycle, that cycle's offered op not accepted, and in_ready_o=1 after.
- Async reset mid-stream: assert rst_n=0 between edges with both stages valid. Require out_valid_o=0 and in_ready_o=1 immediately, and all out_* at 0.
- Random valid/ready toggling over 10k ops against a scoreboard model. Require no loss, no duplication, and in-order results.
